// File: rtl/jogador_automatico_pkg.sv
// Shared types for the memory-game auto-player: state codes shown on the hex
// display and the rotate used to corrupt a jogada for error injection.
package jogador_automatico_pkg;

  localparam int unsigned TimerW = 8;

  typedef enum logic [3:0] {
    StInicial   = 4'h0,
    StPulso     = 4'h1,
    StEspera    = 4'h2,
    StPressiona = 4'h3,
    StSolta     = 4'h4,
    StProxima   = 4'h5,
    StFim       = 4'hF
  } estado_t;

  function automatic logic [3:0] rotl1(input logic [3:0] v);
    return {v[2:0], v[3]};
  endfunction

endpackage

// File: rtl/jogador_automatico_if.sv
// Player <-> game-core link: start pulse and buttons one way, result flags back.
interface jogador_automatico_if;
  logic       iniciar;
  logic [3:0] botoes;
  logic       pronto;
  logic       acertou;
  logic       errou;

  modport master (output iniciar, botoes, input pronto, acertou, errou);
  modport slave  (input iniciar, botoes, output pronto, acertou, errou);
endinterface

// File: rtl/jogador_automatico_contador_timer.sv
// 8-bit up counter with synchronous clear; reached flags the last cycle of a
// len-cycle interval.
module jogador_automatico_contador_timer
  import jogador_automatico_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              clear,
  input  logic              enable,
  input  logic [TimerW-1:0] len,
  output logic              reached
);

  logic [TimerW-1:0] count_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
    end else if (clear) begin
      count_q <= '0;
    end else if (enable) begin
      count_q <= count_q + 1'b1;
    end
  end

  assign reached = (count_q == len - 1'b1);

endmodule

// File: rtl/jogador_automatico.sv
// Auto-player for the memory game: plays round r as jogadas 0..r from sequencia
// with fixed press/release timing, optionally corrupting one press.
module jogador_automatico
  import jogador_automatico_pkg::*;
#(
  parameter int unsigned HOLD      = 10,
  parameter int unsigned GAP       = 10,
  parameter int unsigned START_LEN = 5,
  parameter int unsigned N_JOG     = 16,
  parameter int unsigned ERR_ROUND = 3
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        habilitar,
  input  logic                        err_en,
  input  logic [63:0]                 sequencia,
  jogador_automatico_if.master        jogo,
  output logic                        ocupado,
  output logic [3:0]                  rodada,
  output logic [3:0]                  db_estado
);

  estado_t           estado;
  logic [3:0]        indice;
  logic [3:0]        rodada_q;
  logic              err_q;
  logic              iniciar_q;
  logic [3:0]        botoes_q;
  logic [TimerW-1:0] len;
  logic              reached;
  logic              timed;
  logic              abort;
  logic              sai;
  logic [3:0]        jogada;
  logic [3:0]        botoes_prox;
  logic              unused_acertou;

  assign unused_acertou = jogo.acertou;

  assign timed = (estado == StPulso) || (estado == StEspera) ||
                 (estado == StPressiona) || (estado == StSolta);
  assign abort = (timed || (estado == StProxima)) && (jogo.errou || jogo.pronto);

  // Any exit from the current state restarts the interval timer.
  assign sai = abort || (timed && reached) || (estado == StProxima) ||
               ((estado == StInicial) && habilitar) || ((estado == StFim) && !habilitar);

  always_comb begin
    len = 8'd1;
    case (estado)
      StPulso:            len = 8'(START_LEN);
      StEspera, StSolta:  len = 8'(GAP);
      StPressiona:        len = 8'(HOLD);
      default:            len = 8'd1;
    endcase
  end

  always_comb begin
    jogada      = sequencia[{indice, 2'b00} +: 4];
    botoes_prox = jogada;
    if (err_q && (rodada_q == 4'(ERR_ROUND)) && (indice == rodada_q)) begin
      botoes_prox = rotl1(jogada);
    end
  end

  jogador_automatico_contador_timer u_timer (
    .clock   (clock),
    .reset   (reset),
    .clear   (sai || !timed),
    .enable  (timed),
    .len     (len),
    .reached (reached)
  );

  // Outputs are decoded from the state being left, so they trail it by a cycle.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado    <= StInicial;
      indice    <= '0;
      rodada_q  <= '0;
      err_q     <= 1'b0;
      iniciar_q <= 1'b0;
      botoes_q  <= '0;
    end else begin
      iniciar_q <= (estado == StPulso);
      botoes_q  <= (estado == StPressiona) ? botoes_prox : 4'd0;
      if (abort) begin
        estado <= StFim;
      end else begin
        case (estado)
          StInicial: if (habilitar) begin
            estado   <= StPulso;
            err_q    <= err_en;
            rodada_q <= '0;
            indice   <= '0;
          end
          StPulso:     if (reached) estado <= StEspera;
          StEspera:    if (reached) estado <= StPressiona;
          StPressiona: if (reached) estado <= StSolta;
          StSolta:     if (reached) estado <= StProxima;
          StProxima: begin
            if (indice < rodada_q) begin
              indice <= indice + 1'b1;
              estado <= StPressiona;
            end else if (rodada_q == 4'(N_JOG - 1)) begin
              estado <= StFim;
            end else begin
              rodada_q <= rodada_q + 1'b1;
              indice   <= '0;
              estado   <= StEspera;
            end
          end
          StFim:   if (!habilitar) estado <= StInicial;
          default: estado <= StInicial;
        endcase
      end
    end
  end

  assign jogo.iniciar = iniciar_q;
  assign jogo.botoes  = botoes_q;
  assign ocupado      = (estado != StInicial) && (estado != StFim);
  assign rodada       = rodada_q;
  assign db_estado    = estado;

endmodule
